multiword_serial_adder: RTL and testbench
=========================================

# multiword_serial_adder

Byte-serial multi-word adder that wraps the team's combinational `simple_8bit_adder` as its datapath. It accepts two `8*WORDS`-bit operands and a carry-in through a valid/ready handshake. It feeds the adder one byte per cycle, least-significant byte first, keeping the ripple carry in a register between bytes. It returns the full sum, carry-out and signed-overflow flag through a second valid/ready handshake.

## Interface
- `WORDS`, default 4: operand width in bytes; legal range is ≥ 1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand set on `op_a`/`op_b`/`op_cin` is valid.
- `in_ready` output 1: block can accept an operand set.
- `op_a` input 8*WORDS: addend A, unsigned or two's complement.
- `op_b` input 8*WORDS: addend B.
- `op_cin` input 1: carry into bit 0.
- `out_valid` output 1: result fields are valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output 8*WORDS: `op_a + op_b + op_cin`, modulo 2^(8*WORDS).
- `result_cout` output 1: carry out of the MSB.
- `result_ovf` output 1: signed overflow.
- `busy` output 1: high in RUN and DONE.

## Operation
- **Internal state**
  - Operand registers `a_q`, `b_q`.
  - Carry register `c_q`.
  - Byte index `idx`, width `$clog2(max(WORDS,2))`.
  - Result register.
  - 2-bit FSM with states IDLE, RUN, DONE.
- **Datapath.** One `simple_8bit_adder` instance.
  - Inputs: `a = a_q[8*idx +: 8]`, `b = b_q[8*idx +: 8]`, `cin = c_q`.
  - Outputs `sum` and `cout` are consumed only in RUN.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `op_a`, `op_b`; set `c_q <= op_cin`, `idx <= 0`; go to RUN.
- **RUN**
  - Each cycle: `result[8*idx +: 8] <= sum`, `c_q <= cout`.
  - If `idx == WORDS-1`: go to DONE and set `result_cout <= cout`. Otherwise `idx <= idx+1`.
  - `result_ovf <= (a_q[MSB] == b_q[MSB]) & (sum[7] != a_q[MSB])`, evaluated on the final byte.
- **DONE**
  - `out_valid` = 1.
  - `result`, `result_cout` and `result_ovf` are held stable.
  - On `out_ready`: go to IDLE. Result registers keep their values; `out_valid` drops.
- **Flow control**
  - `in_ready` is 0 in RUN and DONE; `in_valid` in those states is ignored and no operands are latched.
  - No result is ever dropped or overwritten before `out_ready`.
- **`WORDS == 1`:** RUN lasts exactly one cycle.
- **Widths:** no sign extension; `result_cout` is the true unsigned carry out of bit `8*WORDS-1`.

## Timing
- **Reset** (rst high at an edge), values after that edge:
  - State IDLE, `idx` = 0, `c_q` = 0.
  - `result` = 0, `result_cout` = 0, `result_ovf` = 0.
  - `out_valid` = 0, `busy` = 0.
- **`in_ready` during reset:** combinational from state, forced 0 while `rst` is high; 1 in the first cycle after `rst` is released.
- **Reset priority:** reset overrides everything, including mid-RUN and DONE. Any partial result is discarded.
- **Accept:** happens at the edge where `in_valid & in_ready` is high (edge E0).
- **Latency:** byte k is written at edge E(k+1). `out_valid` rises after edge E(WORDS), i.e. WORDS cycles after accept.
- **Handshake completion:** at the edge where `out_valid & out_ready`, the state becomes IDLE. `in_ready` is 1 in the next cycle.
- **Throughput:** one transaction per WORDS+2 cycles minimum.
- **Adder path:** the combinational path is register → adder → register within one cycle. No input-to-output combinational path exists except `in_ready` from `rst` and state.

## Test plan
All scenarios use WORDS=4.
- **Reset:** hold `rst` 3 cycles with random inputs.
  - `out_valid` = 0, `result` = 0, `busy` = 0 throughout.
  - `in_ready` = 1 in the first cycle after release.
- **Byte carry:** A=0x000000FF, B=0x00000001, cin=0.
  - `result` = 0x00000100, `result_cout` = 0, `result_ovf` = 0.
  - `out_valid` rises exactly 4 cycles after accept.
- **Full ripple:** A=0xFFFFFFFF, B=0x00000000, cin=1.
  - `result` = 0x00000000, `result_cout` = 1, `result_ovf` = 0.
- **Overflow, positive:** A=0x7FFFFFFF, B=0x00000001, cin=0.
  - `result` = 0x80000000, `result_cout` = 0, `result_ovf` = 1.
- **Overflow, negative:** A=0x80000000, B=0x80000000.
  - `result` = 0x00000000, `result_cout` = 1, `result_ovf` = 1.
- **Backpressure:** hold `out_ready` low 10 cycles in DONE while driving `in_valid` with new operands.
  - Result remains stable and `in_ready` = 0.
  - After `out_ready` = 1, the next cycle has `out_valid` = 0 and `in_ready` = 1.
  - The new operands are accepted only then.
- **Reset mid-RUN:** assert `rst` for 1 cycle after 2 bytes are processed (A=0x12345678, B=0x11111111).
  - All outputs return to reset values.
  - A following A=0x12345678 + B=0x11111111 yields 0x23456789, cout=0.

Source files
------------

// File: rtl/multiword_serial_adder.sv
// Byte-serial adder for 8*WORDS-bit operands. One byte is summed per cycle
// (LSB first), and the ripple carry is held in a register between bytes.

module simple_8bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[8];
endmodule

module multiword_serial_adder #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORDS-1:0]   op_a,
    input  logic [8*WORDS-1:0]   op_b,
    input  logic                 op_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   result,
    output logic                 result_cout,
    output logic                 result_ovf,
    output logic                 busy
);
    localparam int W  = 8 * WORDS;
    localparam int IW = $clog2((WORDS > 2) ? WORDS : 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    a_reg, b_reg;
    logic            c_reg;
    logic [IW-1:0]   idx_reg;
    logic [7:0]      res_bytes_reg [WORDS];
    logic            cout_reg, ovf_reg;

    logic [7:0]      byte_a, byte_b, byte_sum;
    logic            byte_cout;
    logic            last_byte;

    assign byte_a    = a_reg[8*idx_reg +: 8];
    assign byte_b    = b_reg[8*idx_reg +: 8];
    assign last_byte = (idx_reg == LAST_IDX);

    simple_8bit_adder u_adder (
        .a    (byte_a),
        .b    (byte_b),
        .cin  (c_reg),
        .sum  (byte_sum),
        .cout (byte_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_byte) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= 1'b0;
            idx_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        c_reg   <= op_cin;
                        idx_reg <= '0;
                    end
                end
                RUN: begin
                    c_reg <= byte_cout;
                    if (last_byte) begin
                        cout_reg <= byte_cout;
                        // Signed overflow: like-signed operands, differently signed sum.
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (byte_sum[7] != a_reg[W-1]);
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_res
            always_ff @(posedge clk) begin
                if (rst) begin
                    res_bytes_reg[gi] <= 8'h00;
                end else if (state_reg == RUN && idx_reg == IW'(gi)) begin
                    res_bytes_reg[gi] <= byte_sum;
                end
            end
            assign result[8*gi +: 8] = res_bytes_reg[gi];
        end
    endgenerate

    assign in_ready    = (state_reg == IDLE) && !rst;
    assign out_valid   = (state_reg == DONE);
    assign busy        = (state_reg != IDLE);
    assign result_cout = cout_reg;
    assign result_ovf  = ovf_reg;
endmodule

// File: tb/tb_multiword_serial_adder.sv
// Directed bench for multiword_serial_adder (WORDS=4): vector table plus
// reset, backpressure and reset-mid-RUN sequences.

module tb_multiword_serial_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic        op_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        result_cout;
    logic        result_ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multiword_serial_adder #(.WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_cin      (op_cin),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_cout (result_cout),
        .result_ovf  (result_ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_res;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for out_valid (bounded) and returns cycles elapsed since accept.
    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        if (!out_valid) begin
            errors++;
            checks++;
            $display("FAIL timeout: got out_valid=0 expected out_valid=1 within 20 cycles");
        end
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input logic [31:0] er, input logic ec, input logic eo);
        int cyc;
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        op_cin = cin;
        tick();
        in_valid = 1'b0;
        wait_out(cyc);
        chk("latency", cyc, 4);
        chk("result", result, er);
        chk("result_cout", result_cout, ec);
        chk("result_ovf", result_ovf, eo);
        $display("txn a=%08h b=%08h cin=%0d -> result=%08h cout=%0d ovf=%0d latency=%0d",
                 a, b, cin, result, result_cout, result_ovf, cyc);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_handshake", out_valid, 0);
        chk("in_ready_after_handshake", in_ready, 1);
    endtask

    initial begin
        int cyc;
        logic [31:0] held;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1};

        // Reset with random inputs toggling.
        rst = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            op_a      = $urandom;
            op_b      = $urandom;
            op_cin    = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            chk("reset_out_valid", out_valid, 0);
            chk("reset_result", result, 0);
            chk("reset_busy", busy, 0);
            chk("reset_in_ready", in_ready, 0);
        end
        chk("reset_cout", result_cout, 0);
        chk("reset_ovf", result_ovf, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("in_ready_after_release", in_ready, 1);
        $display("reset sequence done");

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].exp_res, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Backpressure: result held while new operands wait on in_valid.
        in_valid = 1'b1;
        op_a = 32'h000000FF;
        op_b = 32'h00000001;
        op_cin = 1'b0;
        tick();
        op_a = 32'h01010101;
        op_b = 32'h02020202;
        op_cin = 1'b1;
        wait_out(cyc);
        chk("bp_latency", cyc, 4);
        held = result;
        chk("bp_result", held, 32'h00000100);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_result_stable", result, 32'h00000100);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_out_valid_drop", out_valid, 0);
        chk("bp_in_ready_rise", in_ready, 1);
        chk("bp_busy_idle", busy, 0);
        tick();
        in_valid = 1'b0;
        chk("bp_second_accepted", busy, 1);
        wait_out(cyc);
        chk("bp_second_latency", cyc, 4);
        chk("bp_second_result", result, 32'h03030304);
        chk("bp_second_cout", result_cout, 0);
        $display("txn backpressure second result=%08h", result);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-RUN after two bytes processed.
        in_valid = 1'b1;
        op_a = 32'h12345678;
        op_b = 32'h11111111;
        op_cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("midrun_busy", busy, 1);
        chk("midrun_partial", result[15:0], 16'h6789);
        rst = 1'b1;
        tick();
        chk("midrun_rst_result", result, 0);
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_cout", result_cout, 0);
        chk("midrun_rst_ovf", result_ovf, 0);
        rst = 1'b0;
        #1;
        $display("reset mid-RUN done");
        run_txn(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end
endmodule
